// File: rtl/irq_controller_pkg.sv
// irq_controller_pkg: shared FSM encodings and config address map
package irq_controller_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, SERVICE = 2'd2} state_t;
  localparam logic [1:0] CFG_ENABLE = 2'd0;
  localparam logic [1:0] CFG_PENDING = 2'd1;
  localparam logic [1:0] CFG_STATUS = 2'd2;
endpackage

// File: rtl/irq_controller_if.sv
// irq_controller_if: request lines, config bus and core handshake
interface irq_controller_if #(
  parameter int NUM_IRQ = 8,
  parameter int ID_W = 3
);
  logic [NUM_IRQ-1:0] irq_in;
  logic cfg_we;
  logic [1:0] cfg_addr;
  logic [NUM_IRQ-1:0] cfg_wdata;
  logic [NUM_IRQ-1:0] cfg_rdata;
  logic irq_req;
  logic [ID_W-1:0] irq_id;
  logic irq_ack;
  logic irq_eoi;
  modport master (
    output irq_in, cfg_we, cfg_addr, cfg_wdata, irq_ack, irq_eoi,
    input cfg_rdata, irq_req, irq_id
  );
  modport slave (
    input irq_in, cfg_we, cfg_addr, cfg_wdata, irq_ack, irq_eoi,
    output cfg_rdata, irq_req, irq_id
  );
endinterface

// File: rtl/irq_sync_edge.sv
// irq_sync_edge: two-flop synchroniser plus one history flop for rise detection
module irq_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic level,
  output logic rise
);
  logic s1, s2, s3;
  always_ff @(posedge clk)
    if (reset) {s1, s2, s3} <= '0;
    else {s1, s2, s3} <= {async_in, s1, s2};
  assign level = s2;
  assign rise = s2 & ~s3;
endmodule

// File: rtl/irq_controller.sv
// irq_controller: pending/enable state, fixed-priority arbitration and req/ack/eoi handshake
module irq_controller
  import irq_controller_pkg::*;
#(
  parameter int NUM_IRQ = 8,
  parameter int ID_W = 3,
  parameter logic [NUM_IRQ-1:0] EDGE_MASK = '0
) (
  input logic clk,
  input logic reset,
  irq_controller_if.slave bus
);
  logic [NUM_IRQ-1:0] level, rise, pend_q, enable, pending, eligible, clr;
  logic [ID_W-1:0] id_q;
  logic ack_take;
  state_t state, state_n;
  for (genvar i = 0; i < NUM_IRQ; i++) begin : g_sync
    irq_sync_edge u_sync (
      .clk(clk),
      .reset(reset),
      .async_in(bus.irq_in[i]),
      .level(level[i]),
      .rise(rise[i])
    );
  end
  function automatic logic [ID_W-1:0] prio(input logic [NUM_IRQ-1:0] v);
    prio = '0;
    for (int k = NUM_IRQ - 1; k >= 0; k--) if (v[k]) prio = ID_W'(k);
  endfunction
  assign pending = (pend_q & EDGE_MASK) | (level & ~EDGE_MASK);
  assign eligible = pending & enable;
  assign ack_take = state == REQ && bus.irq_ack;
  assign clr = (bus.cfg_we && bus.cfg_addr == CFG_PENDING ? bus.cfg_wdata : '0)
             | (ack_take ? NUM_IRQ'(1) << id_q : '0);
  always_ff @(posedge clk)
    if (reset) begin
      pend_q <= '0;
      enable <= '0;
      id_q <= '0;
      state <= IDLE;
    end else begin
      pend_q <= (rise | (pend_q & ~clr)) & EDGE_MASK;
      if (bus.cfg_we && bus.cfg_addr == CFG_ENABLE) enable <= bus.cfg_wdata;
      if (state == IDLE && |eligible) id_q <= prio(eligible);
      state <= state_n;
    end
  // a REQ whose line loses eligibility is withdrawn unless the ack lands in the same cycle
  always_comb begin
    state_n = IDLE;
    state_n = state == IDLE    ? (|eligible ? REQ : IDLE)
            : state == REQ     ? (bus.irq_ack ? SERVICE : eligible[id_q] ? REQ : IDLE)
            : state == SERVICE ? (bus.irq_eoi ? IDLE : SERVICE)
            : IDLE;
  end
  assign bus.irq_req = state == REQ;
  assign bus.irq_id = id_q;
  assign bus.cfg_rdata = bus.cfg_addr == CFG_ENABLE  ? enable
                       : bus.cfg_addr == CFG_PENDING ? pending
                       : bus.cfg_addr == CFG_STATUS  ? NUM_IRQ'({state == SERVICE, id_q})
                       : '0;
endmodule
